// File: rtl/fft_peak_reader.sv
// fft_peak_reader: scans the FFT output stream and reports the peak |X|^2 bin.
// Optional neighbour-bin magnitudes are enabled with `define FFT_PEAK_NEIGHBORS_EN.
module fft_peak_reader #(
    parameter int bit_width = 16,
    parameter int N         = 512,
    parameter int M         = 9,
    parameter int RD_LAT    = 1,
    parameter int MIN_BIN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [2*bit_width-1:0] wd,
    input  logic                   peak_ready,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [2*bit_width-1:0] peak_mag,
`ifdef FFT_PEAK_NEIGHBORS_EN
    output logic [2*bit_width-1:0] peak_mag_lo,
    output logic [2*bit_width-1:0] peak_mag_hi,
`endif
    output logic                   busy,
    output logic                   overrun
);
    localparam int W = 2 * bit_width;
    localparam logic [M-1:0] LO_BIN   = M'(MIN_BIN);
    localparam logic [M-1:0] HI_BIN   = M'(N / 2);
    localparam logic [M-1:0] LAST_BIN = M'(N - 1);
    localparam logic [1:0]   LAT_END  = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, LAT, SCAN, DRN1, DRN2, RPT} state_t;

    state_t state_q;
    logic done_q;
    logic [1:0] lat_q;
    logic [M-1:0] cnt_q;
    logic s1_vld_q, s2_vld_q;
    logic [M-1:0] s1_bin_q, s2_bin_q;
    logic signed [W-1:0] re_sq_q, im_sq_q;
    logic [W-1:0] s2_mag_q;
    logic [W-1:0] max_mag_q;
    logic [M-1:0] max_bin_q;
    logic pv_q, ovr_q;
    logic [M-1:0] pbin_q;
    logic [W-1:0] pmag_q;

    logic signed [bit_width-1:0] re, im;
    logic signed [W-1:0] re_sq, im_sq;
    logic rise, start, abort, clr, hold;
    logic scanning, s2_ok, in_win, upd;
    logic [W-1:0] nmax_mag;
    logic [M-1:0] nmax_bin;

    assign re    = wd[W-1:bit_width];
    assign im    = wd[bit_width-1:0];
    assign re_sq = re * re;
    assign im_sq = im * im;

    assign rise     = done && !done_q;
    assign start    = rise && (state_q == IDLE || state_q == RPT);
    assign abort    = !done && (state_q == LAT || state_q == SCAN);
    assign clr      = start || abort;
    assign hold     = pv_q && !peak_ready;
    // Only results of the current sweep may touch the running max.
    assign scanning = state_q == SCAN || state_q == DRN1 || state_q == DRN2;
    assign s2_ok    = s2_vld_q && scanning;
    assign in_win   = s2_bin_q >= LO_BIN && s2_bin_q < HI_BIN;
    assign upd      = s2_ok && in_win && (s2_mag_q > max_mag_q);
    assign nmax_mag = upd ? s2_mag_q : max_mag_q;
    assign nmax_bin = upd ? s2_bin_q : max_bin_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= done;
            lat_q     <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_bin_q  <= '0;
            s2_bin_q  <= '0;
            re_sq_q   <= '0;
            im_sq_q   <= '0;
            s2_mag_q  <= '0;
            max_mag_q <= '0;
            max_bin_q <= LO_BIN;
            pv_q      <= 1'b0;
            pbin_q    <= '0;
            pmag_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            done_q   <= done;
            ovr_q    <= 1'b0;
            s1_vld_q <= state_q == SCAN && done;
            s1_bin_q <= cnt_q;
            re_sq_q  <= re_sq;
            im_sq_q  <= im_sq;
            s2_vld_q <= s1_vld_q;
            s2_bin_q <= s1_bin_q;
            s2_mag_q <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
            if (clr) begin
                max_mag_q <= '0;
                max_bin_q <= LO_BIN;
            end else if (upd) begin
                max_mag_q <= s2_mag_q;
                max_bin_q <= s2_bin_q;
            end
            if (pv_q && peak_ready) pv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LAT;
                        lat_q   <= '0;
                    end
                end
                LAT: begin
                    if (abort) begin
                        state_q <= hold ? RPT : IDLE;
                    end else if (lat_q == LAT_END) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                SCAN: begin
                    if (abort) state_q <= hold ? RPT : IDLE;
                    else if (cnt_q == LAST_BIN) state_q <= DRN1;
                    else cnt_q <= cnt_q + M'(1);
                end
                DRN1: state_q <= DRN2;
                DRN2: begin
                    state_q <= RPT;
                    pv_q    <= 1'b1;
                    pbin_q  <= nmax_bin;
                    pmag_q  <= nmax_mag;
                    ovr_q   <= hold;
                end
                RPT: begin
                    if (start) begin
                        state_q <= LAT;
                        lat_q   <= '0;
                    end else if (peak_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign peak_valid = pv_q;
    assign peak_bin   = pbin_q;
    assign peak_mag   = pmag_q;
    assign busy       = state_q != IDLE;
    assign overrun    = ovr_q;

`ifdef FFT_PEAK_NEIGHBORS_EN
    logic [W-1:0] prev_q, lo_q, hi_q, plo_q, phi_q;
    logic arm_q;

    // prev_q trails s2 by one bin; a new max arms capture of the following bin.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            arm_q  <= 1'b0;
            plo_q  <= '0;
            phi_q  <= '0;
        end else begin
            if (clr) begin
                prev_q <= '0;
                lo_q   <= '0;
                hi_q   <= '0;
                arm_q  <= 1'b0;
            end else if (s2_ok) begin
                prev_q <= s2_mag_q;
                if (upd) begin
                    lo_q  <= prev_q;
                    hi_q  <= '0;
                    arm_q <= 1'b1;
                end else if (arm_q) begin
                    hi_q  <= s2_mag_q;
                    arm_q <= 1'b0;
                end
            end
            if (state_q == DRN2) begin
                plo_q <= lo_q;
                phi_q <= hi_q;
            end
        end
    end

    assign peak_mag_lo = plo_q;
    assign peak_mag_hi = phi_q;
`endif
endmodule
